// File: rtl/pipeline_control_unit_pkg.sv
// pipeline_control_unit_pkg: shared state encoding and opcode constants for the pipeline control unit
package pipeline_control_unit_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;
  localparam logic [3:0] OPC_HLT = 4'b1111;
endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = (inc && !(&count_q)) ? count_q + CNT_W'(1) : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: stall/flush arbiter, halt drain tracking and stall/flush statistics for the 5-stage pipeline
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             ifetch_busy,
  input  logic             dmem_busy,
  input  logic             branch_taken,
  input  logic             halt_dec,
  input  logic             halt_wb,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             halted,
  output logic             protocol_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  state_e state_q, state_d;
  logic flush_pending_q, flush_pending_d;
  logic halted_q, halted_d;
  logic perr_q, perr_d;
  logic lu_prev_q, lu_prev_d;
  logic pc_we_c, if_id_we_c, if_id_flush_c, id_ex_we_c, id_ex_flush_c, ex_mem_we_c, mem_wb_we_c;
  logic stall_inc, flush_inc;
  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    perr_d          = perr_q;
    lu_prev_d       = lu_prev_q;
    {pc_we_c, if_id_we_c, if_id_flush_c, id_ex_we_c, id_ex_flush_c, ex_mem_we_c, mem_wb_we_c} = 7'b1101011;
    if (state_q == HALTED || dmem_busy) begin
      {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = '0;
    end else begin
      lu_prev_d = load_use_stall;
      perr_d    = perr_q | (load_use_stall & lu_prev_q);
      if (load_use_stall) begin
        pc_we_c       = 1'b0;
        if_id_we_c    = 1'b0;
        id_ex_flush_c = 1'b1;
      end else if (branch_taken) begin
        if_id_flush_c = 1'b1;
        if (ifetch_busy) flush_pending_d = 1'b1;
      end else if (ifetch_busy) begin
        pc_we_c       = 1'b0;
        if_id_flush_c = 1'b1;
      end
      if (flush_pending_q && !ifetch_busy) begin
        if_id_flush_c   = 1'b1;
        flush_pending_d = 1'b0;
      end
      if (state_q == DRAIN) begin
        pc_we_c       = 1'b0;
        if_id_flush_c = 1'b1;
      end
      if (halt_wb) state_d = HALTED;
      else if (state_q == RUN && halt_dec && !load_use_stall && !branch_taken) state_d = DRAIN;
    end
    halted_d = halted_q | (state_d == HALTED);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
      halted_q        <= 1'b0;
      perr_q          <= 1'b0;
      lu_prev_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      halted_q        <= halted_d;
      perr_q          <= perr_d;
      lu_prev_q       <= lu_prev_d;
    end
  end
  assign pc_we        = rst_n & pc_we_c;
  assign if_id_we     = rst_n & if_id_we_c;
  assign if_id_flush  = !rst_n | if_id_flush_c;
  assign id_ex_we     = rst_n & id_ex_we_c;
  assign id_ex_flush  = !rst_n | id_ex_flush_c;
  assign ex_mem_we    = rst_n & ex_mem_we_c;
  assign mem_wb_we    = rst_n & mem_wb_we_c;
  assign halted       = halted_q;
  assign protocol_err = perr_q;
  assign stall_inc    = !pc_we && state_q != HALTED;
  assign flush_inc    = (if_id_flush || id_ex_flush) && state_q != HALTED;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall_inc), .count(stall_cycles));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush_inc), .count(flush_count));
endmodule
